// File: rtl/modulation_timer.sv
// Per-segment modulation sample index derived from global system time:
// SYNC_IDX[s] = floor(SYS_TIME / FREQ_DIV[s]) mod (CYCLE[s] + 1), one shared serial divider.
module modulation_timer #(
   parameter int NumSegment = 2
) (
   input  logic        CLK,
   input  logic        RST,
   input  logic [63:0] SYS_TIME,
   input  logic [15:0] FREQ_DIV  [NumSegment],
   input  logic [14:0] CYCLE     [NumSegment],
   output logic [14:0] SYNC_IDX  [NumSegment],
   output logic        IDX_VALID [NumSegment]
);
   localparam int SegW = (NumSegment > 1) ? $clog2(NumSegment) : 1;
   localparam logic [SegW-1:0] LastSeg = SegW'(NumSegment - 1);

   typedef enum logic [2:0] {
      S_IDLE      = 3'd0,
      S_LOAD      = 3'd1,
      S_DIV_TIME  = 3'd2,
      S_DIV_CYCLE = 3'd3,
      S_STORE     = 3'd4
   } state_t;

   state_t          r_state;
   state_t          w_state_next;
   logic [SegW-1:0] r_seg;
   logic [63:0]     r_dq;        // dividend shifts out MSB-first while quotient bits shift in
   logic [15:0]     r_rem;
   logic [15:0]     r_divisor;
   logic [15:0]     r_cyc_len;
   logic [5:0]      r_cnt;
   logic            r_zero;
   logic [16:0]     w_trial;
   logic [15:0]     w_rem_next;
   logic            w_qbit;

   // State register
   always_ff @(posedge CLK) begin
      if (RST) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   // Next-state logic; every slot has the same fixed length
   always_comb begin
      w_state_next = r_state;
      case (r_state)
         S_IDLE:      w_state_next = S_LOAD;
         S_LOAD:      w_state_next = S_DIV_TIME;
         S_DIV_TIME: begin
            if (r_cnt == 6'd63) begin
               w_state_next = S_DIV_CYCLE;
            end else begin
               w_state_next = S_DIV_TIME;
            end
         end
         S_DIV_CYCLE: begin
            if (r_cnt == 6'd63) begin
               w_state_next = S_STORE;
            end else begin
               w_state_next = S_DIV_CYCLE;
            end
         end
         S_STORE:     w_state_next = S_LOAD;
         default:     w_state_next = S_IDLE;
      endcase
   end

   // One restoring-division step
   always_comb begin
      w_trial = {r_rem, r_dq[63]};
      if (w_trial >= {1'b0, r_divisor}) begin
         w_qbit     = 1'b1;
         w_rem_next = 16'(w_trial - {1'b0, r_divisor});
      end else begin
         w_qbit     = 1'b0;
         w_rem_next = w_trial[15:0];
      end
   end

   // Divider datapath and segment pointer
   always_ff @(posedge CLK) begin
      if (RST) begin
         r_seg     <= '0;
         r_dq      <= 64'd0;
         r_rem     <= 16'd0;
         r_divisor <= 16'd0;
         r_cyc_len <= 16'd0;
         r_cnt     <= 6'd0;
         r_zero    <= 1'b0;
      end else begin
         case (r_state)
            S_LOAD: begin
               r_dq      <= SYS_TIME;
               r_divisor <= FREQ_DIV[r_seg];
               r_cyc_len <= {1'b0, CYCLE[r_seg]} + 16'd1;
               r_zero    <= (FREQ_DIV[r_seg] == 16'd0);
               r_rem     <= 16'd0;
               r_cnt     <= 6'd0;
            end
            S_DIV_TIME: begin
               // A zero divisor runs harmless dummy steps; r_zero forces the result
               r_dq  <= {r_dq[62:0], w_qbit};
               r_cnt <= r_cnt + 6'd1;
               if (r_cnt == 6'd63) begin
                  r_rem     <= 16'd0;
                  r_divisor <= r_cyc_len;
               end else begin
                  r_rem <= w_rem_next;
               end
            end
            S_DIV_CYCLE: begin
               r_dq  <= {r_dq[62:0], w_qbit};
               r_rem <= w_rem_next;
               r_cnt <= r_cnt + 6'd1;
            end
            S_STORE: begin
               if (r_seg == LastSeg) begin
                  r_seg <= '0;
               end else begin
                  r_seg <= r_seg + {{(SegW-1){1'b0}}, 1'b1};
               end
            end
            default: begin
               r_cnt <= 6'd0;
            end
         endcase
      end
   end

   // Registered outputs, written only in the owning segment's STORE
   always_ff @(posedge CLK) begin
      if (RST) begin
         for (int s = 0; s < NumSegment; s++) begin
            SYNC_IDX[s]  <= 15'd0;
            IDX_VALID[s] <= 1'b0;
         end
      end else if (r_state == S_STORE) begin
         SYNC_IDX[r_seg]  <= r_zero ? 15'd0 : r_rem[14:0];
         IDX_VALID[r_seg] <= 1'b1;
      end
   end
endmodule

// File: tb/tb_modulation_timer.sv
// Self-checking bench for modulation_timer: directed literal checks plus a
// per-cycle comparison against an arithmetic model of the slot schedule.
module tb_modulation_timer;
   localparam int NS   = 2;
   localparam int SLOT = 130;

   logic        clk      = 1'b0;
   logic        rst      = 1'b1;
   logic [63:0] sys_time = 64'd0;
   logic [15:0] freq_div  [NS];
   logic [14:0] cycle_len [NS];
   logic [14:0] sync_idx  [NS];
   logic        idx_valid [NS];

   int n_tests = 0;
   int n_fail  = 0;
   int cyc     = 0;
   bit chk_en  = 1'b0;

   logic [14:0] exp_idx [NS];
   logic        exp_vld [NS];
   logic [63:0] snap_t;
   logic [15:0] snap_fd;
   logic [14:0] snap_c;
   int          snap_seg = 0;

   always #5 clk = ~clk;

   modulation_timer #(.NumSegment(NS)) dut (
      .CLK       (clk),
      .RST       (rst),
      .SYS_TIME  (sys_time),
      .FREQ_DIV  (freq_div),
      .CYCLE     (cycle_len),
      .SYNC_IDX  (sync_idx),
      .IDX_VALID (idx_valid)
   );

   function automatic logic [14:0] ref_idx(input logic [63:0] t, input logic [15:0] fd,
                                           input logic [14:0] c);
      logic [63:0] q;
      if (fd == 16'd0) return 15'd0;
      q = t / {48'd0, fd};
      return 15'(q % ({49'd0, c} + 64'd1));
   endfunction

   // Reference model: slot k loads at cycle 1+130k for segment k mod NS, result visible at 131+130k
   initial begin
      for (int s = 0; s < NS; s++) begin
         exp_idx[s] = 15'd0;
         exp_vld[s] = 1'b0;
      end
      forever begin
         @(posedge clk);
         chk_en = 1'b1;
         if (rst) begin
            for (int s = 0; s < NS; s++) begin
               exp_idx[s] = 15'd0;
               exp_vld[s] = 1'b0;
            end
            cyc = 0;
         end else begin
            if (cyc >= 1 && (cyc - 1) % SLOT == 0) begin
               snap_seg = ((cyc - 1) / SLOT) % NS;
               snap_t   = sys_time;
               snap_fd  = freq_div[snap_seg];
               snap_c   = cycle_len[snap_seg];
            end
            if (cyc >= SLOT && (cyc - SLOT) % SLOT == 0) begin
               exp_idx[snap_seg] = ref_idx(snap_t, snap_fd, snap_c);
               exp_vld[snap_seg] = 1'b1;
            end
            cyc = cyc + 1;
         end
      end
   end

   // Compare every cycle, away from the active edge
   initial begin
      forever begin
         @(negedge clk);
         if (chk_en) begin
            for (int s = 0; s < NS; s++) begin
               n_tests++;
               if (sync_idx[s] !== exp_idx[s]) begin
                  n_fail++;
                  $display("FAIL model_idx seg=%0d cyc=%0d got %0d want %0d",
                           s, cyc, sync_idx[s], exp_idx[s]);
               end
               n_tests++;
               if (idx_valid[s] !== exp_vld[s]) begin
                  n_fail++;
                  $display("FAIL model_vld seg=%0d cyc=%0d got %0d want %0d",
                           s, cyc, idx_valid[s], exp_vld[s]);
               end
            end
         end
      end
   end

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] want);
      n_tests++;
      if (act !== want) begin
         n_fail++;
         $display("FAIL %s cyc=%0d got %0d want %0d", name, cyc, act, want);
      end
   endtask

   task automatic do_reset();
      @(posedge clk); #1; rst = 1'b1;
      @(posedge clk); #1;
      @(posedge clk); #1; rst = 1'b0;
   endtask

   task automatic wait_cyc(input int n);
      int guard;
      guard = 0;
      while (cyc != n && guard < 2000) begin
         @(posedge clk); #1;
         guard++;
      end
      if (cyc != n) begin
         n_tests++;
         n_fail++;
         $display("FAIL wait_cyc got %0d want %0d", cyc, n);
      end
   endtask

   task automatic set_all(input logic [15:0] fd, input logic [14:0] c);
      for (int s = 0; s < NS; s++) begin
         freq_div[s]  = fd;
         cycle_len[s] = c;
      end
   endtask

   initial begin
      int sel;
      set_all(16'd10, 15'd3);

      // Basic index and first-valid timing
      sys_time = 64'd123;
      do_reset();
      wait_cyc(2);   sys_time = 64'd137;
      wait_cyc(130); check("t1_vld0_early", idx_valid[0], 64'd0);
      wait_cyc(131); check("t1_idx0", sync_idx[0], 64'd0);
                     check("t1_vld0", idx_valid[0], 64'd1);
                     check("t1_vld1_early", idx_valid[1], 64'd0);
      wait_cyc(261); check("t1_idx1", sync_idx[1], 64'd1);
                     check("t1_vld1", idx_valid[1], 64'd1);

      // Extremes
      freq_div[0] = 16'd1;     cycle_len[0] = 15'd32767;
      freq_div[1] = 16'd65535; cycle_len[1] = 15'd2;
      sys_time = 64'hFFFF_FFFF_FFFF_FFFF;
      do_reset();
      wait_cyc(2);   sys_time = 64'd393209;
      wait_cyc(131); check("t2_max", sync_idx[0], 64'd32767);
      wait_cyc(132); sys_time = 64'd0;
      wait_cyc(261); check("t2_bigdiv", sync_idx[1], 64'd2);
      wait_cyc(391); check("t2_zero_time", sync_idx[0], 64'd0);

      // Zero divider on segment 1
      set_all(16'd10, 15'd3);
      freq_div[1] = 16'd0; cycle_len[1] = 15'd5;
      sys_time = 64'd123;
      do_reset();
      wait_cyc(260); check("t3_vld1_early", idx_valid[1], 64'd0);
      wait_cyc(261); check("t3_idx1", sync_idx[1], 64'd0);
                     check("t3_vld1", idx_valid[1], 64'd1);
                     check("t3_idx0", sync_idx[0], 64'd0);
      wait_cyc(262); freq_div[1] = 16'd7;
      wait_cyc(521); check("t3_idx1_div7", sync_idx[1], 64'd5);
      wait_cyc(522); freq_div[1] = 16'd0;
      wait_cyc(781); check("t3_idx1_rezero", sync_idx[1], 64'd0);

      // Mid-computation parameter change
      set_all(16'd10, 15'd3);
      sys_time = 64'd123;
      do_reset();
      wait_cyc(50);  cycle_len[0] = 15'd9;
      wait_cyc(131); check("t4_old_cycle", sync_idx[0], 64'd0);
      wait_cyc(132); sys_time = 64'd200;
      wait_cyc(391); check("t4_new_cycle_200", sync_idx[0], 64'd0);
      wait_cyc(392); sys_time = 64'd210;
      wait_cyc(651); check("t4_new_cycle_210", sync_idx[0], 64'd1);

      // Reset during DIV_CYCLE of segment 0
      set_all(16'd10, 15'd3);
      sys_time = 64'd137;
      do_reset();
      wait_cyc(262); check("t5_pre_idx0", sync_idx[0], 64'd1);
                     check("t5_pre_idx1", sync_idx[1], 64'd1);
      wait_cyc(360); rst = 1'b1;
      @(posedge clk); #1;
      check("t5_rst_idx0", sync_idx[0], 64'd0);
      check("t5_rst_vld0", idx_valid[0], 64'd0);
      check("t5_rst_idx1", sync_idx[1], 64'd0);
      check("t5_rst_vld1", idx_valid[1], 64'd0);
      rst = 1'b0;
      wait_cyc(130); check("t5_post_vld0_early", idx_valid[0], 64'd0);
      wait_cyc(131); check("t5_post_vld0", idx_valid[0], 64'd1);
                     check("t5_post_idx0", sync_idx[0], 64'd1);

      // Free-running time with random parameters, crossing the 64-bit wrap
      for (int s = 0; s < NS; s++) begin
         freq_div[s]  = 16'($urandom_range(261, 65535));
         cycle_len[s] = 15'($urandom_range(0, 15));
      end
      sys_time = 64'hFFFF_FFFF_FFFF_FFFF - 64'($urandom_range(0, 1500));
      do_reset();
      for (int i = 0; i < 3000; i++) begin
         @(posedge clk); #1;
         sys_time = sys_time + 64'd1;
         if ($urandom_range(0, 63) == 0) begin
            sel = $urandom_range(0, NS - 1);
            freq_div[sel] = 16'($urandom_range(261, 65535));
            if ($urandom_range(0, 1) == 0) begin
               cycle_len[sel] = 15'($urandom);
            end else begin
               cycle_len[sel] = 15'($urandom_range(0, 15));
            end
         end
      end

      @(posedge clk); #1;
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
